// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by the interface, the prefetch buffer and the top level.
package instr_fetch_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int INSTR_W   = 16;
    localparam int BUF_DEPTH = 2;

    localparam logic [ADDR_W-1:0]  RESET_PC = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP      = 16'h0000;
    localparam logic [ADDR_W-1:0]  PC_INC   = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM, control and decode-side handshake bundle of the fetch sequencer.
// master = fetch sequencer, slave = ROM/pipeline environment.
interface instr_fetch_ctrl_if;
    import instr_fetch_ctrl_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               busy;
    logic               misalign_err;

    modport master (
        output rom_addr, out_valid, out_instr, out_pc, busy, misalign_err,
        input  rom_data, redirect_valid, redirect_addr, halt, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_instr, out_pc, busy, misalign_err,
        output rom_data, redirect_valid, redirect_addr, halt, out_ready
    );

endinterface

// File: rtl/instr_fetch_ctrl_buf.sv
// Prefetch FIFO of {pc, instr} entries; flush beats push.
// Push on a full buffer is accepted only when a pop happens on the same edge.
module instr_fetch_ctrl_buf
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  fetch_ent_t i_data,
    output logic       o_full,
    output logic       o_empty,
    output fetch_ent_t o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_ent_t   r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [AW:0]  w_cnt;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_cnt     = r_wr - r_rd;
    assign o_full    = (w_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr == r_rd);
    assign o_head    = r_mem[r_rd[AW-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer update; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push)
            r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, fills the prefetch
// buffer from the async ROM and hands {pc, instr} to decode.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_RESET_PC  = RESET_PC,
    parameter int                P_BUF_DEPTH = BUF_DEPTH
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_ctrl_if.master  bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_misalign;

    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic       w_redir;
    fetch_ent_t w_head;
    fetch_ent_t w_new;

    assign w_redir = bus.redirect_valid & (r_state != ST_IDLE);
    assign w_pop   = ~w_empty & bus.out_ready;
    assign w_push  = (r_state == ST_RUN) & ~w_redir & ~bus.halt
                   & (~w_full | w_pop);
    assign w_new   = '{pc: r_fetch_pc, instr: bus.rom_data};

    instr_fetch_ctrl_buf #(
        .DEPTH (P_BUF_DEPTH)
    ) u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_data  (w_new),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign bus.rom_addr     = r_fetch_pc;
    assign bus.out_valid    = ~w_empty;
    assign bus.out_instr    = w_empty ? NOP : w_head.instr;
    assign bus.out_pc       = w_empty ? '0 : w_head.pc;
    assign bus.busy         = (r_state == ST_RUN);
    assign bus.misalign_err = r_misalign;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: IDLE leaves on the first edge out of reset
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   w_state_nxt = ST_RUN;
            ST_RUN:    if (bus.halt)  w_state_nxt = ST_HALTED;
            ST_HALTED: if (!bus.halt) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Fetch PC: redirect target (halfword aligned) or sequential advance
    always_ff @(posedge clk) begin
        if (rst)
            r_fetch_pc <= P_RESET_PC;
        else if (w_redir)
            r_fetch_pc <= {bus.redirect_addr[ADDR_W-1:1], 1'b0};
        else if (w_push)
            r_fetch_pc <= r_fetch_pc + PC_INC;
    end

    // Sticky flag for odd redirect targets
    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (w_redir && bus.redirect_addr[0])
            r_misalign <= 1'b1;
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed stimulus pushes expected
// {pc, instr} pops; a negedge monitor compares every accepted handshake.
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_ent_t exp_q[$];

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h0000: rom_fn = 16'h0000;
            16'h0002: rom_fn = 16'h8102;
            16'h0052: rom_fn = 16'h0110;
            default:  rom_fn = a ^ 16'h5A5A;
        endcase
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        exp_q.push_back('{pc: pc, instr: rom_fn(pc)});
    endtask

    // Monitor: every accepted handshake must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h expected none",
                         bus.out_pc);
            end else begin
                fetch_ent_t e;
                e = exp_q.pop_front();
                chk("pop_pc", 32'(bus.out_pc), 32'(e.pc));
                chk("pop_instr", 32'(bus.out_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        bus.out_ready      = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mis", 32'(bus.misalign_err), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        chk("rst_pc", 32'(bus.out_pc), 0);
        chk("rst_instr", 32'(bus.out_instr), 0);

        // Release with out_ready high: pops 0,2,4
        expect_pc(16'h0000);
        expect_pc(16'h0002);
        expect_pc(16'h0004);
        rst = 1'b0;
        chk("idle_busy", 32'(bus.busy), 0);
        tick();
        chk("run_busy", 32'(bus.busy), 1);
        chk("c1_valid", 32'(bus.out_valid), 0);
        chk("c1_addr", 32'(bus.rom_addr), 16'h0000);
        tick();
        chk("c2_valid", 32'(bus.out_valid), 1);
        chk("c2_pc", 32'(bus.out_pc), 16'h0000);
        chk("c2_addr", 32'(bus.rom_addr), 16'h0002);
        tick();
        chk("c3_pc", 32'(bus.out_pc), 16'h0002);
        chk("c3_instr", 32'(bus.out_instr), 16'h8102);
        chk("c3_addr", 32'(bus.rom_addr), 16'h0004);
        tick();
        tick();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_addr", 32'(bus.rom_addr), 16'h0000);
        tick();

        // Back-pressure: buffer fills with 0 and 2, address freezes at 4
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pc", 32'(bus.out_pc), 16'h0000);
            chk("bp_instr", 32'(bus.out_instr), 16'h0000);
            chk("bp_addr", 32'(bus.rom_addr), 16'h0004);
        end
        chk("bp_valid", 32'(bus.out_valid), 1);

        // Stream 0..0x3C, redirect to 0x52 as 0x3C is accepted
        for (int k = 0; k <= 30; k++) expect_pc(16'(2 * k));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("pre_redir_pc", 32'(bus.out_pc), 16'h003C);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0052;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_bubble", 32'(bus.out_valid), 0);
        chk("redir_addr", 32'(bus.rom_addr), 16'h0052);
        expect_pc(16'h0052);
        tick();
        chk("redir_valid", 32'(bus.out_valid), 1);
        chk("redir_pc", 32'(bus.out_pc), 16'h0052);
        chk("redir_instr", 32'(bus.out_instr), 16'h0110);

        // Odd redirect target 0x45 fetches from 0x44 and flags misalign
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0045;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_flag", 32'(bus.misalign_err), 1);
        chk("mis_addr", 32'(bus.rom_addr), 16'h0044);
        chk("mis_bubble", 32'(bus.out_valid), 0);
        expect_pc(16'h0044);
        tick();

        // Halt: 0x44 drains, fetch parks at 0x46, then resumes there
        bus.halt = 1'b1;
        tick();
        chk("halt_busy", 32'(bus.busy), 0);
        chk("halt_valid", 32'(bus.out_valid), 0);
        tick();
        chk("halt_addr", 32'(bus.rom_addr), 16'h0046);
        bus.halt = 1'b0;
        tick();
        chk("resume_busy", 32'(bus.busy), 1);
        expect_pc(16'h0046);
        tick();
        chk("resume_pc", 32'(bus.out_pc), 16'h0046);
        chk("mis_sticky", 32'(bus.misalign_err), 1);

        // Redirect to 0xFFFE: sequence wraps to 0x0000
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'hFFFE;
        tick();
        bus.redirect_valid = 1'b0;
        expect_pc(16'hFFFE);
        expect_pc(16'h0000);
        tick();
        chk("wrap_pc0", 32'(bus.out_pc), 16'hFFFE);
        tick();
        chk("wrap_pc1", 32'(bus.out_pc), 16'h0000);
        chk("wrap_addr", 32'(bus.rom_addr), 16'h0002);
        tick();

        // Reset mid-stream restarts at RESET_PC and clears the sticky flag
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst2_valid", 32'(bus.out_valid), 0);
        chk("rst2_mis", 32'(bus.misalign_err), 0);
        chk("rst2_addr", 32'(bus.rom_addr), 16'h0000);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        expect_pc(16'h0000);
        expect_pc(16'h0002);
        tick();
        tick();
        chk("rst2_pc", 32'(bus.out_pc), 16'h0000);
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
